// File: rtl/hs_cdc_arb_pkg.sv
// Shared types and helpers for the handshake-CDC channel arbiter.
package hs_cdc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int unsigned MAX_BURST_W = 8;

  function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hs_cdc_arb_rr_picker.sv
// Combinational rotating-priority picker: first set bit of req scanning upward from rr_ptr.
module hs_cdc_arb_rr_picker
  import hs_cdc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               hit,
  output logic [ID_W-1:0]    idx
);

  int unsigned     pos;
  logic [ID_W-1:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    pos  = 0;
    cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = ID_W'(pos);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hs_cdc_channel_arbiter.sv
// Round-robin burst arbiter sharing one 2-phase handshake CDC channel between NUM_REQ sources.
// Optional output skid register: define HS_CDC_ARB_OUT_REG_EN.
module hs_cdc_channel_arbiter
  import hs_cdc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter type         DATA_TYPE = logic,
  parameter int unsigned MAX_BURST = 1,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  DATA_TYPE           req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output DATA_TYPE           out_data,
  output logic [ID_W-1:0]    out_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant
);

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [MAX_BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]        owner_inc, pick_ptr, pick_idx;
  logic                   pick_hit, core_valid, core_ready, core_xfer, rel;
  DATA_TYPE               core_data;

  assign owner_inc  = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
  // rst gating drops any in-flight transfer without a req_ready pulse
  assign core_valid = (state_q == ARB_GRANT) && req_valid[owner_q] && !rst;
  assign core_data  = req_data[owner_q];
  assign core_xfer  = core_valid && core_ready;
  assign rel        = (state_q == ARB_GRANT) &&
                      ((core_xfer && (burst_cnt_q == MAX_BURST_W'(MAX_BURST - 1))) ||
                       !req_valid[owner_q]);
  // On release the re-pick starts just past the owner, leaving it lowest priority
  assign pick_ptr   = rel ? owner_inc : rr_ptr_q;

  hs_cdc_arb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (pick_ptr),
    .hit    (pick_hit),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_hit) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (core_xfer) burst_cnt_d = burst_cnt_q + 1'b1;
        if (rel) begin
          rr_ptr_d = owner_inc;
          if (pick_hit) begin
            owner_d     = pick_idx;
            burst_cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((state_q == ARB_GRANT) && (owner_q == ID_W'(i))) begin
        grant[i]     = 1'b1;
        req_ready[i] = core_xfer;
      end
    end
  end

`ifdef HS_CDC_ARB_OUT_REG_EN
  DATA_TYPE        skid_data_q [2];
  logic [ID_W-1:0] skid_id_q [2];
  logic            skid_wr_q, skid_rd_q, skid_pop;
  logic [1:0]      skid_cnt_q;

  assign core_ready = (skid_cnt_q != 2'd2);
  assign skid_pop   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_id_q[0]   <= '0;
      skid_id_q[1]   <= '0;
      skid_wr_q      <= 1'b0;
      skid_rd_q      <= 1'b0;
      skid_cnt_q     <= 2'd0;
    end else begin
      if (core_xfer) begin
        skid_data_q[skid_wr_q] <= core_data;
        skid_id_q[skid_wr_q]   <= owner_q;
        skid_wr_q              <= ~skid_wr_q;
      end
      if (skid_pop) skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, core_xfer} - {1'b0, skid_pop};
    end
  end

  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = skid_data_q[skid_rd_q];
  assign out_id    = skid_id_q[skid_rd_q];
`else
  assign core_ready = out_ready;
  assign out_valid  = core_valid;
  assign out_data   = core_data;
  assign out_id     = owner_q;
`endif

endmodule

// File: tb/tb_hs_cdc_channel_arbiter.sv
// Scoreboard bench for hs_cdc_channel_arbiter: a 4-requester/burst-3 and a 3-requester/burst-1 instance.
module tb_hs_cdc_channel_arbiter;

  typedef logic [7:0] byte_t;
  typedef struct {
    int    id;
    byte_t data;
  } exp_t;

`ifdef HS_CDC_ARB_OUT_REG_EN
  localparam int Lat = 2;
  localparam byte_t RstData = 8'h00;
`else
  localparam int Lat = 1;
  localparam byte_t RstData = 8'h85;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_t      a_req_data [4];
  logic [3:0] a_req_valid, a_req_ready, a_grant, a_hs;
  byte_t      a_out_data;
  logic [1:0] a_out_id;
  logic       a_out_valid, a_out_ready;

  byte_t      b_req_data [3];
  logic [2:0] b_req_valid, b_req_ready, b_grant, b_hs;
  byte_t      b_out_data;
  logic [1:0] b_out_id;
  logic       b_out_valid, b_out_ready;

  hs_cdc_channel_arbiter #(.NUM_REQ(4), .DATA_TYPE(byte_t), .MAX_BURST(3)) u_a (
    .clk       (clk),
    .rst       (rst),
    .req_data  (a_req_data),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .out_data  (a_out_data),
    .out_id    (a_out_id),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .grant     (a_grant)
  );

  hs_cdc_channel_arbiter #(.NUM_REQ(3), .DATA_TYPE(byte_t), .MAX_BURST(1)) u_b (
    .clk       (clk),
    .rst       (rst),
    .req_data  (b_req_data),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .out_data  (b_out_data),
    .out_id    (b_out_id),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .grant     (b_grant)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   a_left [4], a_seq [4], exp_seq_a [4];
  int   b_left [3], b_seq [3], exp_seq_b [3];
  int   a_pulses;
  exp_t qa [$];
  exp_t qb [$];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic byte_t pay(int i, int s);
    logic [3:0] hi, lo;
    hi = 4'(i);
    lo = 4'(s);
    return {hi, lo} ^ 8'h85;
  endfunction

  task automatic push_a(int id);
    exp_t e;
    e.id = id;
    e.data = pay(id, exp_seq_a[id]);
    exp_seq_a[id]++;
    qa.push_back(e);
  endtask

  task automatic push_b(int id);
    exp_t e;
    e.id = id;
    e.data = pay(id, exp_seq_b[id]);
    exp_seq_b[id]++;
    qb.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      a_req_valid[i] = (a_left[i] != 0);
      a_req_data[i]  = pay(i, a_seq[i]);
    end
    for (int i = 0; i < 3; i++) begin
      b_req_valid[i] = (b_left[i] != 0);
      b_req_data[i]  = pay(i, b_seq[i]);
    end
  endtask

  // Called at the negedge; checks the transfer about to commit, then advances one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) check_eq("a_unexpected_xfer", 32'(a_out_id), 32'hFFFF);
      else begin
        e = qa.pop_front();
        check_eq("a_id", 32'(a_out_id), 32'(e.id));
        check_eq("a_data", 32'(a_out_data), 32'(e.data));
      end
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check_eq("b_unexpected_xfer", 32'(b_out_id), 32'hFFFF);
      else begin
        e = qb.pop_front();
        check_eq("b_id", 32'(b_out_id), 32'(e.id));
        check_eq("b_data", 32'(b_out_data), 32'(e.data));
      end
    end
    if (b_out_valid) check_eq("b_id_range", 32'(b_out_id < 2'd3), 32'd1);
    check_eq("a_ready_legal",
             32'($onehot0(a_req_ready) && ((a_req_ready & ~a_req_valid) == 4'd0)), 32'd1);
    check_eq("b_ready_legal",
             32'($onehot0(b_req_ready) && ((b_req_ready & ~b_req_valid) == 3'd0)), 32'd1);
    a_hs = a_req_ready;
    b_hs = b_req_ready;
    a_pulses += $countones(a_req_ready);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (a_hs[i]) begin a_left[i]--; a_seq[i]++; end
    for (int i = 0; i < 3; i++) if (b_hs[i]) begin b_left[i]--; b_seq[i]++; end
    apply();
    @(negedge clk);
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("drain_a", 32'(qa.size()), 32'd0);
    check_eq("drain_b", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    int   cyc;
    byte_t stall_data;
    rst = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a_left[i] = 0; a_seq[i] = 0; exp_seq_a[i] = 0; end
    for (int i = 0; i < 3; i++) begin b_left[i] = 0; b_seq[i] = 0; exp_seq_b[i] = 0; end
    a_pulses = 0;
    apply();
    @(negedge clk);
    repeat (3) tick();

    check_eq("rst_a_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_a_grant", 32'(a_grant), 32'd0);
    check_eq("rst_a_id", 32'(a_out_id), 32'd0);
    check_eq("rst_a_ready", 32'(a_req_ready), 32'd0);
    check_eq("rst_a_data", 32'(a_out_data), 32'(RstData));
    check_eq("rst_b_valid", 32'(b_out_valid), 32'd0);
    check_eq("rst_b_grant", 32'(b_grant), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester 2, payload 0xA5
    a_pulses = 0;
    a_left[2] = 1;
    push_a(2);
    apply();
    #1;
    for (int k = 0; k < Lat; k++) begin
      check_eq("a_lat_wait", 32'(a_out_valid), 32'd0);
      tick();
    end
    check_eq("a_lat_valid", 32'(a_out_valid), 32'd1);
    check_eq("a_lat_data", 32'(a_out_data), 32'hA5);
    drain(cyc);
    repeat (2) tick();
    check_eq("a_single_pulse", 32'(a_pulses), 32'd1);

    // All three valid, burst 1: 0,1,2,0,1,2 with no bubbles
    for (int i = 0; i < 3; i++) b_left[i] = 2;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) push_b(i);
    apply();
    drain(cyc);
    check_eq("b_nobubble", 32'(cyc), 32'(Lat + 6));
    repeat (2) tick();

    // Non-power-of-2 wrap: req 2 alone, then 0 and 1
    b_left[2] = 1;
    push_b(2);
    apply();
    drain(cyc);
    repeat (2) tick();
    check_eq("b_ptr_wrap", 32'(u_b.rr_ptr_q), 32'd0);
    b_left[0] = 1;
    b_left[1] = 1;
    push_b(0);
    push_b(1);
    apply();
    drain(cyc);
    repeat (2) tick();

    // Burst 3 with 0 and 1 valid: 0,0,0,1,1,1,0,0,0
    a_left[0] = 6;
    a_left[1] = 3;
    for (int i = 0; i < 3; i++) push_a(0);
    for (int i = 0; i < 3; i++) push_a(1);
    for (int i = 0; i < 3; i++) push_a(0);
    apply();
    drain(cyc);
    check_eq("a_burst_nobubble", 32'(cyc), 32'(Lat + 9));
    repeat (3) tick();

    // Stall: owner 1 with out_ready low for 5 cycles
    a_out_ready = 1'b0;
    a_left[1] = 1;
    push_a(1);
    stall_data = qa[0].data;
    apply();
    repeat (Lat) tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", 32'(a_out_valid), 32'd1);
      check_eq("stall_id", 32'(a_out_id), 32'd1);
      check_eq("stall_data", 32'(a_out_data), 32'(stall_data));
`ifndef HS_CDC_ARB_OUT_REG_EN
      check_eq("stall_grant", 32'(a_grant), 32'h2);
`endif
      tick();
    end
    a_out_ready = 1'b1;
    drain(cyc);
    repeat (2) tick();

    // Reset mid-burst after two transfers by owner 2
    a_left[0] = 2;
    a_left[2] = 5;
    push_a(2);
    push_a(2);
    apply();
    drain(cyc);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_mid_ready", 32'(a_req_ready), 32'd0);
    tick();
    check_eq("rst_after_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_after_grant", 32'(a_grant), 32'd0);
    check_eq("rst_after_ptr", 32'(u_a.rr_ptr_q), 32'd0);
    rst = 1'b0;
    push_a(0);
    push_a(0);
    for (int i = 0; i < 3; i++) push_a(2);
    drain(cyc);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
